// File: rtl/sar_multich_sequencer.sv
// sar_multich_sequencer
//   Multi-channel successive-approximation ADC controller. Scans the enabled
//   analog mux channels in ascending order. Each channel first gets a mux settle
//   phase, then a WIDTH-step binary search against an external comparator.
//   Scanning can be one-shot or continuous, and can be aborted at any time.
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   start          1-cycle scan request, honoured only in idle
//   continuous     rescan after the last channel while high
//   abort          return to idle next cycle, discarding any in-flight result
//   ch_mask        enabled channels, captured at start and at every scan wrap
//   comparator     1 = analog input >= dac_code (used on tick cycles only)
//   dac_code       trial code driven to the DAC
//   mux_sel        analog mux channel select
//   busy           high outside idle
//   sample_valid   1-cycle pulse, sample_data/sample_ch valid
//   sample_data    converted code, held until the next sample_valid
//   sample_ch      channel of sample_data
//   scan_done      1-cycle pulse with the last channel's sample_valid
module sar_multich_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SETTLE_CYCLES = 5000,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              comparator,
  output logic [WIDTH-1:0]  dac_code,
  output logic [CH_W-1:0]   mux_sel,
  output logic              busy,
  output logic              sample_valid,
  output logic [WIDTH-1:0]  sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              scan_done
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StSettle, StTrial, StStore} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   dac_q, dac_d;
  logic [CH_W-1:0]    mux_q, mux_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CH_W-1:0]    ch_q, ch_d;

  logic               tick;
  logic [CH_W-1:0]    first_ch;
  logic [CH_W-1:0]    next_ch;
  logic               has_next;
  logic [IDX_W-1:0]   idx_m1;

  assign tick   = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign idx_m1 = idx_q - IDX_W'(1);

  // first_ch: lowest enabled channel of the live mask (capture points).
  // next_ch: lowest captured channel above the current one.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(mux_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dac_d        = dac_q;
    mux_d        = mux_q;
    mask_d       = mask_q;
    data_d       = data_q;
    ch_d         = ch_q;
    sample_valid = 1'b0;
    scan_done    = 1'b0;

    if (state_q != StIdle) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start && (|ch_mask)) begin
          mask_d  = ch_mask;
          mux_d   = first_ch;
          dac_d   = '0;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        dac_d = '0;
        if (tick) begin
          dac_d   = {1'b1, {(WIDTH - 1){1'b0}}};
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = StTrial;
        end
      end
      StTrial: begin
        if (tick) begin
          if (!comparator) dac_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            dac_d[idx_m1] = 1'b1;
            idx_d         = idx_m1;
          end else begin
            state_d = StStore;
          end
        end
      end
      StStore: begin
        sample_valid = 1'b1;
        data_d       = dac_q;
        ch_d         = mux_q;
        cnt_d        = '0;
        dac_d        = '0;
        if (has_next) begin
          mux_d   = next_ch;
          state_d = StSettle;
        end else begin
          scan_done = 1'b1;
          if (continuous && (|ch_mask)) begin
            mask_d  = ch_mask;
            mux_d   = first_ch;
            state_d = StSettle;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything above, including this cycle's result pulse.
    if (abort) begin
      state_d      = StIdle;
      dac_d        = '0;
      cnt_d        = '0;
      data_d       = data_q;
      ch_d         = ch_q;
      sample_valid = 1'b0;
      scan_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      mux_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      mux_q   <= mux_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  // The result is presented during the STORE cycle itself, straight from the
  // converged trial code, and is registered for holding afterwards.
  assign dac_code    = dac_q;
  assign mux_sel     = mux_q;
  assign busy        = (state_q != StIdle);
  assign sample_data = sample_valid ? dac_q : data_q;
  assign sample_ch   = sample_valid ? mux_q : ch_q;

endmodule

// File: tb/tb_sar_multich_sequencer.sv
module tb_sar_multich_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, continuous, abort, comparator;
  logic [3:0]  ch_mask;
  logic [7:0]  dac_code, sample_data;
  logic [1:0]  mux_sel, sample_ch;
  logic        busy, sample_valid, scan_done;

  logic        start12, cont12, abort12, comparator12;
  logic [0:0]  mask12;
  logic [11:0] dac12, data12;
  logic [0:0]  mux12, ch12;
  logic        busy12, valid12, done12;

  logic [7:0]  vin [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  typedef struct {
    int ch;
    int data;
    int done;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t q12[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator front-end model: per-channel analog level vs the trial code.
  assign comparator   = (vin[mux_sel] >= dac_code);
  assign comparator12 = (12'hABC >= dac12);

  sar_multich_sequencer #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .ch_mask(ch_mask), .comparator(comparator), .dac_code(dac_code), .mux_sel(mux_sel),
    .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ch(sample_ch), .scan_done(scan_done)
  );

  sar_multich_sequencer #(.WIDTH(12), .NUM_CH(1), .SETTLE_CYCLES(4)) u_dut12 (
    .clk(clk), .reset(reset), .start(start12), .continuous(cont12), .abort(abort12),
    .ch_mask(mask12), .comparator(comparator12), .dac_code(dac12), .mux_sel(mux12),
    .busy(busy12), .sample_valid(valid12), .sample_data(data12),
    .sample_ch(ch12), .scan_done(done12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input int data, input int done, input int c);
    exp_t e;
    e.ch = ch; e.data = data; e.done = done; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start is driven in cycle t0 and sampled on the following edge.
  task automatic pulse_start(input logic [3:0] mask);
    @(posedge clk);
    #1;
    ch_mask = mask;
    start   = 1'b1;
    t0      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Scoreboard monitors: pop an expectation on every result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", {31'd0, sample_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("sample_ch", {30'd0, sample_ch}, e.ch);
        check("sample_data", {24'd0, sample_data}, e.data);
        check("scan_done", {31'd0, scan_done}, e.done);
        check("valid_cycle", cyc, e.cyc);
      end
    end else if (scan_done) begin
      check("done_without_valid", {31'd0, scan_done}, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid12) begin
      if (q12.size() == 0) begin
        check("unexpected_valid12", {31'd0, valid12}, 32'd0);
      end else begin
        e = q12.pop_front();
        check("sample_ch12", {31'd0, ch12}, e.ch);
        check("sample_data12", {20'd0, data12}, e.data);
        check("scan_done12", {31'd0, done12}, e.done);
        check("valid_cycle12", cyc, e.cyc);
      end
    end
  end

  initial begin
    exp_t e12;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; ch_mask = '0;
    start12 = 1'b0; cont12 = 1'b0; abort12 = 1'b0; mask12 = 1'b1;
    vin[0] = 8'hA5; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
    step(3);
    check("rst_dac", {24'd0, dac_code}, 32'd0);
    check("rst_mux", {30'd0, mux_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_data", {24'd0, sample_data}, 32'd0);
    check("rst_done", {31'd0, scan_done}, 32'd0);
    reset = 1'b0;

    // 1: single channel, one-shot
    pulse_start(4'b0001);
    push(0, 8'hA5, 1, t0 + 37);
    step(36);
    check("s1_busy_in_store", {31'd0, busy}, 32'd1);
    step(1);
    check("s1_busy_drop", {31'd0, busy}, 32'd0);
    check("s1_drained", q.size(), 32'd0);

    // 2: four channels, extremes and mid-scale
    vin[0] = 8'h00; vin[1] = 8'hFF; vin[2] = 8'h80; vin[3] = 8'h7F;
    pulse_start(4'b1111);
    push(0, 8'h00, 0, t0 + 37);
    push(1, 8'hFF, 0, t0 + 74);
    push(2, 8'h80, 0, t0 + 111);
    push(3, 8'h7F, 1, t0 + 148);
    step(150);
    check("s2_drained", q.size(), 32'd0);
    check("s2_idle", {31'd0, busy}, 32'd0);

    // 3: sparse mask, continuous, dropped during the second ch1 conversion
    vin[0] = 8'h12; vin[1] = 8'h34; vin[2] = 8'h56; vin[3] = 8'h78;
    continuous = 1'b1;
    pulse_start(4'b1010);
    push(1, 8'h34, 0, t0 + 37);
    push(3, 8'h78, 1, t0 + 74);
    push(1, 8'h34, 0, t0 + 111);
    push(3, 8'h78, 1, t0 + 148);
    step(89);
    continuous = 1'b0;
    step(59);
    check("s3_idle_after_wrap", {31'd0, busy}, 32'd0);
    check("s3_drained", q.size(), 32'd0);

    // 4: abort in the 5th trial step of ch2, then a fresh scan
    pulse_start(4'b1111);
    push(0, 8'h12, 0, t0 + 37);
    push(1, 8'h34, 0, t0 + 74);
    step(95);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("s4_abort_busy", {31'd0, busy}, 32'd0);
    check("s4_abort_dac", {24'd0, dac_code}, 32'd0);
    check("s4_hold_data", {24'd0, sample_data}, 32'h34);
    step(60);
    check("s4_drained", q.size(), 32'd0);
    pulse_start(4'b0101);
    push(0, 8'h12, 0, t0 + 37);
    push(2, 8'h56, 1, t0 + 74);
    step(76);
    check("s4_restart_drained", q.size(), 32'd0);

    // 5: empty mask ignored; start and mask changes while busy ignored
    pulse_start(4'b0000);
    check("s5_empty_busy", {31'd0, busy}, 32'd0);
    step(3);
    check("s5_empty_busy_later", {31'd0, busy}, 32'd0);
    pulse_start(4'b0011);
    push(0, 8'h12, 0, t0 + 37);
    push(1, 8'h34, 1, t0 + 74);
    step(19);
    start = 1'b1;
    ch_mask = 4'b1100;
    step(1);
    start = 1'b0;
    step(56);
    check("s5_idle", {31'd0, busy}, 32'd0);
    check("s5_drained", q.size(), 32'd0);

    // 6: reset mid-trial, then 12-bit single-channel instance
    pulse_start(4'b1000);
    step(19);
    check("s6_pre_mux", {30'd0, mux_sel}, 32'd3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("s6_rst_dac", {24'd0, dac_code}, 32'd0);
    check("s6_rst_mux", {30'd0, mux_sel}, 32'd0);
    check("s6_rst_busy", {31'd0, busy}, 32'd0);
    check("s6_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("s6_rst_data", {24'd0, sample_data}, 32'd0);
    check("s6_rst_ch", {30'd0, sample_ch}, 32'd0);
    check("s6_rst_done", {31'd0, scan_done}, 32'd0);
    step(40);
    check("s6_no_result", q.size(), 32'd0);

    @(posedge clk);
    #1;
    start12 = 1'b1;
    t0 = cyc;
    e12.ch = 0; e12.data = 12'hABC; e12.done = 1; e12.cyc = t0 + 53;
    q12.push_back(e12);
    step(1);
    start12 = 1'b0;
    step(54);
    check("s6_w12_drained", q12.size(), 32'd0);
    check("s6_w12_idle", {31'd0, busy12}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
